td4_core: RTL and testbench
===========================

// Module: td4_core
// PURPOSE
//  Single-cycle TD4 CPU core: program counter, A/B registers, carry flag, I/O ports.
//  Drives the 4-bit instruction ROM address and consumes its 8-bit word in the same cycle.
//  Executes one instruction per enabled clock; this is the stage directly downstream of the ROM.
// PARAMETERS
//  RESET_PC   4'h0  PC value loaded at reset
//  RESET_OUT  4'h0  OUT_PORT value loaded at reset
// PORTS
//  CLK       in   1  clock, all state updates on rising edge
//  N_RESET   in   1  reset, synchronous, active-low
//  EN        in   1  execute enable; 0 = hold all state (timer pacing / single-step)
//  ADDRESS   out  4  ROM address = PC
//  INSTR     in   8  ROM word: [7:4] opcode, [3:0] immediate Im
//  IN_PORT   in   4  input port, sampled by IN instructions
//  OUT_PORT  out  4  registered output port
//  CARRY     out  1  carry flag
// BEHAVIOUR
//  - Reset (N_RESET=0 at edge): PC=RESET_PC, A=0, B=0, C=0, OUT_PORT=RESET_OUT; overrides EN.
//  - ADDRESS is combinational from PC. INSTR must be valid in the same cycle. Latency 1 cycle/instr.
//  - EN=0: PC, A, B, C, OUT_PORT hold. EN=1: execute INSTR at the edge.
//  - Datapath: sum[4:0] = src + Im (4-bit + 4-bit). C <= sum[4] on every executed instr.
//    Only ADD can produce 1; all other opcodes give src + 0 / Im + 0 -> C cleared.
//  - Opcodes (PC <= PC+1 mod 16 unless jumping; PC wraps F->0):
//    0000 ADD A,Im  A <= sum[3:0] (A+Im)   | 0101 ADD B,Im  B <= (B+Im)[3:0]
//    0011 MOV A,Im  A <= Im                | 0111 MOV B,Im  B <= Im
//    0001 MOV A,B   A <= B                 | 0100 MOV B,A   B <= A
//    0010 IN A      A <= IN_PORT           | 0110 IN B      B <= IN_PORT
//    1001 OUT B     OUT_PORT <= B          | 1011 OUT Im    OUT_PORT <= Im
//    1111 JMP Im    PC <= Im
//    1110 JNC Im    PC <= Im if C==0 (C value before this instr), else PC+1
//  - JNC tests the old carry, then clears C (sum of 0+Im never carries).
//  - Undefined opcodes (1000,1010,1100,1101): NOP, PC+1, C cleared, no other state change.
//  - MOV A,B and MOV B,A read pre-edge register values (no swap hazard).
//  - JMP to own address (e.g. JMP F at PC=F) = halt loop; core keeps executing it.
//  - N_RESET low mid-program: state reloads at that edge; first fetch after release is RESET_PC.
// CONFIGURATION
//  TD4_HALT_DETECT_EN defined: extra output HALT (1 bit, reset 0). Set at the edge that
//   executes JMP Im with Im==PC (EN=1); sticky until reset. State updates continue unchanged.
//  Undefined: no HALT port; core behaviour identical otherwise.
// TESTING
//  1 Reset: N_RESET=0 for 2 edges -> ADDRESS=0, OUT_PORT=0, CARRY=0; release -> ADDRESS=0 first cycle.
//  2 Timer program (B7,01,E1,...): after 1 cycle OUT_PORT=7; ADD/JNC loop runs 16 ADDs,
//    16th ADD sets C, following JNC falls through to PC=3; A=0 after wrap.
//  3 Carry: MOV A,F; ADD A,1 -> A=0, C=1; next MOV B,3 -> C=0, B=3.
//  4 EN=0 for 5 cycles mid-loop -> PC/A/B/C/OUT_PORT unchanged; EN=1 resumes at same ADDRESS.
//  5 I/O and moves: IN_PORT=A; IN A; MOV B,A; OUT B -> OUT_PORT=A; OUT Im 5 -> OUT_PORT=5.
//  6 JMP F at PC=F -> ADDRESS stays F; with TD4_HALT_DETECT_EN HALT=1 one edge later and stays 1;
//    PC=F then undefined opcode/PC wrap check: NOP at F -> ADDRESS=0.

Source files
------------

// File: rtl/td4_core.sv
// TD4 single-cycle core: PC, A/B registers, carry flag and I/O ports, one instruction per enabled edge.
// Optional TD4_HALT_DETECT_EN adds a sticky HALT output for the JMP-to-self idle loop.
module td4_core #(
    parameter logic [3:0] RESET_PC  = 4'h0,
    parameter logic [3:0] RESET_OUT = 4'h0
) (
    input  logic       CLK,
    input  logic       N_RESET,
    input  logic       EN,
    output logic [3:0] ADDRESS,
    input  logic [7:0] INSTR,
    input  logic [3:0] IN_PORT,
    output logic [3:0] OUT_PORT,
    output logic       CARRY
`ifdef TD4_HALT_DETECT_EN
   ,output logic       HALT
`endif
);

    localparam logic [3:0] OP_ADD_A = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A  = 4'b0010;
    localparam logic [3:0] OP_MOV_A = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B = 4'b0101;
    localparam logic [3:0] OP_IN_B  = 4'b0110;
    localparam logic [3:0] OP_MOV_B = 4'b0111;
    localparam logic [3:0] OP_OUT_B = 4'b1001;
    localparam logic [3:0] OP_OUT_I = 4'b1011;
    localparam logic [3:0] OP_JNC   = 4'b1110;
    localparam logic [3:0] OP_JMP   = 4'b1111;

    logic [3:0] pc, reg_a, reg_b, out_q;
    logic       c_q;

    logic [3:0] op, im;
    logic [3:0] src, addend;
    logic [4:0] sum;
    logic       wr_a, wr_b, wr_out, ld_pc;
    logic [3:0] pc_next;

    assign op       = INSTR[7:4];
    assign im       = INSTR[3:0];
    assign ADDRESS  = pc;
    assign OUT_PORT = out_q;
    assign CARRY    = c_q;

    // Every instruction goes through the one adder; moves and jumps add zero, so only ADD carries.
    always_comb begin
        src    = 4'h0;
        addend = 4'h0;
        wr_a   = 1'b0;
        wr_b   = 1'b0;
        wr_out = 1'b0;
        ld_pc  = 1'b0;
        case (op)
            OP_ADD_A:  begin src = reg_a;   addend = im; wr_a = 1'b1; end
            OP_MOV_AB: begin src = reg_b;                wr_a = 1'b1; end
            OP_IN_A:   begin src = IN_PORT;              wr_a = 1'b1; end
            OP_MOV_A:  begin                addend = im; wr_a = 1'b1; end
            OP_MOV_BA: begin src = reg_a;                wr_b = 1'b1; end
            OP_ADD_B:  begin src = reg_b;   addend = im; wr_b = 1'b1; end
            OP_IN_B:   begin src = IN_PORT;              wr_b = 1'b1; end
            OP_MOV_B:  begin                addend = im; wr_b = 1'b1; end
            OP_OUT_B:  begin src = reg_b;                wr_out = 1'b1; end
            OP_OUT_I:  begin                addend = im; wr_out = 1'b1; end
            OP_JMP:    begin                addend = im; ld_pc = 1'b1; end
            OP_JNC:    begin                addend = im; ld_pc = ~c_q; end
            default:   ;
        endcase
    end

    assign sum     = {1'b0, src} + {1'b0, addend};
    assign pc_next = ld_pc ? sum[3:0] : pc + 4'd1;

    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            pc    <= RESET_PC;
            reg_a <= 4'h0;
            reg_b <= 4'h0;
            c_q   <= 1'b0;
            out_q <= RESET_OUT;
        end else if (EN) begin
            pc  <= pc_next;
            c_q <= sum[4];
            if (wr_a)   reg_a <= sum[3:0];
            if (wr_b)   reg_b <= sum[3:0];
            if (wr_out) out_q <= sum[3:0];
        end
    end

`ifdef TD4_HALT_DETECT_EN
    logic halt_q;
    assign HALT = halt_q;

    always_ff @(posedge CLK) begin
        if (!N_RESET)
            halt_q <= 1'b0;
        else if (EN && op == OP_JMP && im == pc)
            halt_q <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_td4_core.sv
// Directed bench for td4_core: small hand-written programs in a combinational ROM model.
module tb_td4_core;

    logic       CLK = 1'b0;
    logic       N_RESET;
    logic       EN;
    logic [3:0] ADDRESS;
    logic [7:0] INSTR;
    logic [3:0] IN_PORT;
    logic [3:0] OUT_PORT;
    logic       CARRY;
`ifdef TD4_HALT_DETECT_EN
    logic       HALT;
`endif

    logic [7:0] rom [16];
    int total = 0;
    int bad   = 0;

    assign INSTR = rom[ADDRESS];

    always #5 CLK = ~CLK;

    td4_core #(.RESET_PC(4'h0), .RESET_OUT(4'h0)) dut (
        .CLK(CLK), .N_RESET(N_RESET), .EN(EN), .ADDRESS(ADDRESS), .INSTR(INSTR),
        .IN_PORT(IN_PORT), .OUT_PORT(OUT_PORT), .CARRY(CARRY)
`ifdef TD4_HALT_DETECT_EN
       ,.HALT(HALT)
`endif
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    endtask

    task automatic do_reset();
        N_RESET = 1'b0;
        step(1);
        N_RESET = 1'b1;
    endtask

    task automatic test_reset();
        clear_rom();
        EN = 1'b0;
        N_RESET = 1'b0;
        IN_PORT = 4'h0;
        step(2);
        total++; if (ADDRESS !== 4'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", ADDRESS); end
        total++; if (OUT_PORT !== 4'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", OUT_PORT); end
        total++; if (CARRY !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", CARRY); end
`ifdef TD4_HALT_DETECT_EN
        total++; if (HALT !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b exp=0", HALT); end
`endif
        N_RESET = 1'b1;
        EN = 1'b1;
        #2;
        total++; if (ADDRESS !== 4'h0) begin bad++; $display("FAIL release_addr got=%h exp=0", ADDRESS); end
    endtask

    // 0:OUT 7  1:ADD A,1  2:JNC 1  3:MOV B,A  4:OUT B  5:JMP 5
    task automatic load_timer();
        clear_rom();
        rom[0] = 8'hB7; rom[1] = 8'h01; rom[2] = 8'hE1;
        rom[3] = 8'h40; rom[4] = 8'h90; rom[5] = 8'hF5;
    endtask

    task automatic test_timer();
        load_timer();
        do_reset();
        step(1);
        total++; if (OUT_PORT !== 4'h7) begin bad++; $display("FAIL timer_out7 got=%h exp=7", OUT_PORT); end
        total++; if (ADDRESS !== 4'h1) begin bad++; $display("FAIL timer_addr1 got=%h exp=1", ADDRESS); end
        step(30); // 15 ADD/JNC pairs: A=15, no carry yet
        total++; if (ADDRESS !== 4'h1 || CARRY !== 1'b0) begin bad++; $display("FAIL timer_pre got=%h/%b exp=1/0", ADDRESS, CARRY); end
        step(1);
        total++; if (CARRY !== 1'b1) begin bad++; $display("FAIL timer_carry got=%b exp=1", CARRY); end
        step(1);
        total++; if (ADDRESS !== 4'h3 || CARRY !== 1'b0) begin bad++; $display("FAIL timer_fall got=%h/%b exp=3/0", ADDRESS, CARRY); end
        step(2);
        total++; if (OUT_PORT !== 4'h0) begin bad++; $display("FAIL timer_a_wrap got=%h exp=0", OUT_PORT); end
    endtask

    task automatic test_carry();
        clear_rom();
        rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'h73; rom[3] = 8'h90;
        rom[4] = 8'h40; rom[5] = 8'h90; rom[6] = 8'hF6;
        do_reset();
        step(2);
        total++; if (CARRY !== 1'b1) begin bad++; $display("FAIL carry_set got=%b exp=1", CARRY); end
        step(1);
        total++; if (CARRY !== 1'b0) begin bad++; $display("FAIL carry_clr got=%b exp=0", CARRY); end
        step(1);
        total++; if (OUT_PORT !== 4'h3) begin bad++; $display("FAIL carry_b3 got=%h exp=3", OUT_PORT); end
        step(2);
        total++; if (OUT_PORT !== 4'h0) begin bad++; $display("FAIL carry_a0 got=%h exp=0", OUT_PORT); end
    endtask

    task automatic test_enable();
        load_timer();
        do_reset();
        step(8); // OUT 7 then four ADDs: A=4, PC=2
        EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            total++;
            if (ADDRESS !== 4'h2 || OUT_PORT !== 4'h7 || CARRY !== 1'b0) begin
                bad++; $display("FAIL en_hold%0d got=%h/%h/%b exp=2/7/0", i, ADDRESS, OUT_PORT, CARRY);
            end
        end
        EN = 1'b1;
        step(1);
        total++; if (ADDRESS !== 4'h1) begin bad++; $display("FAIL en_resume got=%h exp=1", ADDRESS); end
        step(23); // 11 more pairs then the 16th ADD
        total++; if (CARRY !== 1'b1 || ADDRESS !== 4'h2) begin bad++; $display("FAIL en_count got=%b/%h exp=1/2", CARRY, ADDRESS); end
    endtask

    task automatic test_io();
        clear_rom();
        rom[0] = 8'h20; rom[1] = 8'h40; rom[2] = 8'h90; rom[3] = 8'hB5;
        rom[4] = 8'h60; rom[5] = 8'h90; rom[6] = 8'h3C; rom[7] = 8'h10;
        rom[8] = 8'h4F; rom[9] = 8'h90; rom[10] = 8'hFA;
        IN_PORT = 4'hA;
        do_reset();
        step(3);
        total++; if (OUT_PORT !== 4'hA) begin bad++; $display("FAIL io_in_a got=%h exp=a", OUT_PORT); end
        step(1);
        total++; if (OUT_PORT !== 4'h5) begin bad++; $display("FAIL io_out_im got=%h exp=5", OUT_PORT); end
        IN_PORT = 4'h6;
        step(2);
        total++; if (OUT_PORT !== 4'h6) begin bad++; $display("FAIL io_in_b got=%h exp=6", OUT_PORT); end
        // MOV A,C; MOV A,B (A=6); MOV B,A (B=6); OUT B
        step(4);
        total++; if (OUT_PORT !== 4'h6) begin bad++; $display("FAIL io_moves got=%h exp=6", OUT_PORT); end
    endtask

    task automatic test_halt();
        clear_rom();
        rom[0] = 8'hFF; rom[15] = 8'hFF;
        do_reset();
        step(1);
        total++; if (ADDRESS !== 4'hF) begin bad++; $display("FAIL halt_jmp got=%h exp=f", ADDRESS); end
`ifdef TD4_HALT_DETECT_EN
        total++; if (HALT !== 1'b0) begin bad++; $display("FAIL halt_early got=%b exp=0", HALT); end
`endif
        step(1);
        total++; if (ADDRESS !== 4'hF) begin bad++; $display("FAIL halt_loop got=%h exp=f", ADDRESS); end
`ifdef TD4_HALT_DETECT_EN
        total++; if (HALT !== 1'b1) begin bad++; $display("FAIL halt_set got=%b exp=1", HALT); end
        step(3);
        total++; if (HALT !== 1'b1) begin bad++; $display("FAIL halt_sticky got=%b exp=1", HALT); end
`endif
        do_reset();
        total++; if (ADDRESS !== 4'h0) begin bad++; $display("FAIL halt_rst got=%h exp=0", ADDRESS); end
`ifdef TD4_HALT_DETECT_EN
        total++; if (HALT !== 1'b0) begin bad++; $display("FAIL halt_rst_clr got=%b exp=0", HALT); end
`endif
        // MOV A,F; JMP E; E: ADD A,1 (C=1); F: NOP -> wraps to 0, clears C
        clear_rom();
        rom[0] = 8'h3F; rom[1] = 8'hFE; rom[14] = 8'h01; rom[15] = 8'h80;
        do_reset();
        step(3);
        total++; if (ADDRESS !== 4'hF || CARRY !== 1'b1) begin bad++; $display("FAIL wrap_pre got=%h/%b exp=f/1", ADDRESS, CARRY); end
        step(1);
        total++; if (ADDRESS !== 4'h0 || CARRY !== 1'b0) begin bad++; $display("FAIL wrap_nop got=%h/%b exp=0/0", ADDRESS, CARRY); end
    endtask

    initial begin
        test_reset();
        test_timer();
        test_carry();
        test_enable();
        test_io();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
